mux4_rr_arbiter: RTL and testbench
==================================

// Module: mux4_rr_arbiter
// PURPOSE
//   Round-robin arbiter that shares one WIDTH-bit output channel among four requesters.
//   Each requester raises req[i] with its word on in<i>. The block grants one requester and
//   captures that word through a 4:1 select into an output register. It then presents the word
//   on a valid/ready channel and pulses ack[i] when the word is accepted.
//   It sits in front of downstream consumers (ALU/register path) and sequences the input mux.
// PARAMETERS
//   WIDTH  16  data width of in0..in3 and out_data
// PORTS
//   clk        in   1      single clock; all state updates on its rising edge
//   rst_n      in   1      reset, synchronous, active-low
//   en         in   1      1 = new grants allowed; 0 = finish the current word, grant no more
//   req        in   4      req[i]=1: requester i has a word on in<i>
//   in0..in3   in   WIDTH  requester data words
//   ack        out  4      one-hot, 1-cycle pulse: word of requester i accepted downstream
//   out_valid  out  1      out_data/out_sel hold a word
//   out_ready  in   1      downstream accepts when out_valid&out_ready (the "accept" cycle)
//   out_data   out  WIDTH  captured word; stable while out_valid=1
//   out_sel    out  2      index of the granted requester; stable while out_valid=1
// BEHAVIOUR
//   Reset (rst_n=0 at an edge): state=IDLE, out_valid=0, out_data=0, out_sel=0, last=3.
//     req0 is first in priority after reset. Reset in BUSY drops the word; no ack is issued.
//   Round-robin: candidates in order last+1, last+2, last+3, last (mod 4);
//     the first with an eligible req wins.
//   States:
//     IDLE: out_valid=0. If en=1 and |req, grant winner g at this edge:
//       out_data<=in<g>, out_sel<=g, out_valid<=1, ->BUSY.
//       Latency: req high in cycle N -> out_valid=1 in cycle N+1.
//     BUSY: out_valid=1; out_data and out_sel are frozen (not tracking in<g> or req).
//       No accept: remain BUSY.
//       Accept: ack[out_sel]=1 combinationally in this cycle; last<=out_sel.
//         Then re-arbitrate in the same cycle with req[out_sel] masked.
//         That requester's req is treated as consumed for this cycle.
//         If en=1 and another req is eligible: capture the new winner and stay BUSY
//           (back-to-back, no bubble).
//         Otherwise: ->IDLE, out_valid<=0.
//   ack: ack = out_valid & out_ready ? (1<<out_sel) : 0. Never more than one bit set.
//     ack is never 1 outside an accept cycle.
//   Requester protocol: hold req[i] and in<i> until the grant edge; keep req high until ack[i].
//     Drop req after ack unless another word is ready.
//     If req[g] drops while BUSY, the captured word still completes and ack[g] still pulses.
//   Single requester streaming: the mask in the accept cycle gives one word per two cycles
//     (BUSY, IDLE, BUSY, ...).
//   en=0: no new grants. A word already in BUSY completes normally.
//     en is sampled only at grant decisions.
//   out_ready while out_valid=0: ignored.
//   req bits with no grant: ignored and cause no state change.
// TESTING
//   1. Reset: rst_n=0 for 2 clk, req=4'b1111.
//      -> out_valid=0, out_data=0, ack=0 throughout. After release, first grant is out_sel=0.
//   2. Single requester: req=4'b0100, in2=16'hBEEF, out_ready=1.
//      -> out_valid next cycle, out_data=16'hBEEF, out_sel=2, ack=4'b0100 that cycle.
//      -> out_valid pattern 1,0,1,0 while req held.
//   3. Round-robin fairness: req=4'b1111 held, in0..in3 = 16'h0000, 16'h1111, 16'h2222, 16'h3333,
//      out_ready=1. -> out_sel sequence 0,1,2,3,0,... on consecutive cycles; no bubble.
//      -> ack one-hot matches out_sel.
//   4. Backpressure: grant in1=16'h1234, out_ready=0 for 5 cycles while in1 changes to 16'hFFFF
//      and req0 rises. -> out_data stays 16'h1234, out_sel=1, ack=0.
//      On out_ready=1: ack=4'b0010, next out_sel=0.
//   5. en gating: en=0 with req=4'b0011 -> no out_valid.
//      en 1->0 while BUSY -> current word completes with ack, then IDLE.
//   6. Mid-operation reset: BUSY with out_sel=3, assert rst_n=0.
//      -> no ack[3]; out_valid=0 next edge; after release, priority starts at req0.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter: grants one of four requesters, captures its word and presents it downstream.
// Latency: req in cycle N -> out_valid in cycle N+1. Backpressure: word held while out_ready=0.
module mux4_rr_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    output logic [3:0]       ack,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_sel
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_q;
    logic [1:0]       last_q;
    logic [1:0]       out_sel_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_valid_q;

    logic             accept;
    logic [3:0]       sel_onehot;
    logic [3:0]       elig;
    logic [1:0]       base;
    logic             grant_vld_d;
    logic [1:0]       grant_idx_d;
    logic [WIDTH-1:0] grant_dat_d;

    // Returns {found, index}: first eligible requester searching last+1 .. last.
    function automatic logic [2:0] rr_pick(input logic [1:0] last, input logic [3:0] req_v);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!res[2] && req_v[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign sel_onehot = 4'b0001 << out_sel_q;
    // A reset edge drops the word, so an accept coinciding with reset must not be acknowledged.
    assign accept     = rst_n & out_valid_q & out_ready;
    assign ack        = accept ? sel_onehot : 4'b0000;

    // In the accept cycle the departing requester's req is consumed, and it becomes the new 'last'.
    assign elig = (state_q == BUSY) ? (req & ~sel_onehot) : req;
    assign base = (state_q == BUSY) ? out_sel_q : last_q;

    always_comb begin
        logic [2:0] pick;
        pick        = rr_pick(base, elig);
        grant_vld_d = pick[2] & en;
        grant_idx_d = pick[1:0];
        case (pick[1:0])
            2'd0:    grant_dat_d = in0;
            2'd1:    grant_dat_d = in1;
            2'd2:    grant_dat_d = in2;
            default: grant_dat_d = in3;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= 2'd3;
            out_sel_q   <= 2'd0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_vld_d) begin
                        out_data_q  <= grant_dat_d;
                        out_sel_q   <= grant_idx_d;
                        out_valid_q <= 1'b1;
                        state_q     <= BUSY;
                    end
                end
                BUSY: begin
                    if (accept) begin
                        last_q <= out_sel_q;
                        if (grant_vld_d) begin
                            out_data_q <= grant_dat_d;
                            out_sel_q  <= grant_idx_d;
                        end else begin
                            out_valid_q <= 1'b0;
                            state_q     <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed scenarios plus randomized traffic against a word-level model.
module tb_mux4_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [3:0]  req;
    logic [15:0] in_w [4];
    logic [3:0]  ack;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [1:0]  out_sel;

    int checks = 0;
    int failures = 0;

    // Model: the word currently held for downstream and the last served requester.
    logic        m_valid;
    logic [15:0] m_data;
    logic [1:0]  m_sel;
    logic [1:0]  m_last;

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req),
        .in0(in_w[0]), .in1(in_w[1]), .in2(in_w[2]), .in3(in_w[3]),
        .ack(ack), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sel(out_sel)
    );

    function automatic int pick(int last, logic [3:0] elig);
        for (int k = 1; k <= 4; k++) begin
            if (elig[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_ack();
        logic [3:0] a;
        a = 4'b0000;
        if (rst_n && m_valid && out_ready) a[m_sel] = 1'b1;
        return a;
    endfunction

    // Advance one clock; model moves to the state implied by the inputs before the edge.
    task automatic tick();
        logic        n_valid;
        logic [15:0] n_data;
        logic [1:0]  n_sel;
        logic [1:0]  n_last;
        logic [3:0]  elig;
        int          g;
        n_valid = m_valid; n_data = m_data; n_sel = m_sel; n_last = m_last;
        if (!rst_n) begin
            n_valid = 0; n_data = 0; n_sel = 0; n_last = 3;
        end else if (!m_valid) begin
            g = en ? pick(int'(m_last), req) : -1;
            if (g >= 0) begin
                n_valid = 1; n_data = in_w[g]; n_sel = 2'(g);
            end
        end else if (out_ready) begin
            n_last = m_sel;
            elig = req;
            elig[m_sel] = 1'b0;
            g = en ? pick(int'(m_sel), elig) : -1;
            if (g >= 0) begin
                n_data = in_w[g]; n_sel = 2'(g);
            end else begin
                n_valid = 0;
            end
        end
        @(posedge clk);
        m_valid = n_valid; m_data = n_data; m_sel = n_sel; m_last = n_last;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0; en = 1; req = 4'b0000; out_ready = 0;
        tick();
        tick();
        rst_n = 1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; en = 1; req = 4'b1111; out_ready = 1;
        for (int i = 0; i < 4; i++) in_w[i] = 16'hA5A5 + 16'(i);
        for (int c = 0; c < 2; c++) begin
            tick();
            #1;
            checks++;
            if (out_valid !== 1'b0 || out_data !== 16'h0000 || ack !== 4'b0000) begin
                failures++;
                $display("FAIL reset_state cyc=%0d: valid=%b data=%h ack=%b, required 0/0000/0000",
                         c, out_valid, out_data, ack);
            end
        end
        rst_n = 1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 16'hA5A5) begin
            failures++;
            $display("FAIL reset_first_grant: valid=%b sel=%0d data=%h, required 1/0/a5a5",
                     out_valid, out_sel, out_data);
        end
    endtask

    task automatic test_single();
        logic exp_v;
        do_reset();
        req = 4'b0100; in_w[2] = 16'hBEEF; out_ready = 1;
        tick();
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'hBEEF || out_sel !== 2'd2 || ack !== 4'b0100) begin
            failures++;
            $display("FAIL single_grant: valid=%b data=%h sel=%0d ack=%b, required 1/beef/2/0100",
                     out_valid, out_data, out_sel, ack);
        end
        exp_v = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            exp_v = ~exp_v;
            checks++;
            if (out_valid !== exp_v) begin
                failures++;
                $display("FAIL single_stream cyc=%0d: valid=%b, required %b", c, out_valid, exp_v);
            end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        in_w[0] = 16'h0000; in_w[1] = 16'h1111; in_w[2] = 16'h2222; in_w[3] = 16'h3333;
        req = 4'b1111; out_ready = 1;
        for (int c = 0; c < 8; c++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_sel !== 2'(c % 4) || out_data !== 16'(16'h1111 * (c % 4))
                || ack !== 4'(1 << (c % 4))) begin
                failures++;
                $display("FAIL round_robin cyc=%0d: valid=%b sel=%0d data=%h ack=%b, required sel=%0d",
                         c, out_valid, out_sel, out_data, ack, c % 4);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        req = 4'b0010; in_w[1] = 16'h1234; in_w[0] = 16'h0F0F; out_ready = 0;
        tick();
        in_w[1] = 16'hFFFF; req = 4'b0011;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'h1234 || out_sel !== 2'd1 || ack !== 4'b0000) begin
                failures++;
                $display("FAIL backpressure_hold cyc=%0d: valid=%b data=%h sel=%0d ack=%b, required 1/1234/1/0000",
                         c, out_valid, out_data, out_sel, ack);
            end
            tick();
        end
        out_ready = 1;
        #1;
        checks++;
        if (ack !== 4'b0010) begin
            failures++;
            $display("FAIL backpressure_ack: ack=%b, required 0010", ack);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 16'h0F0F) begin
            failures++;
            $display("FAIL backpressure_next: valid=%b sel=%0d data=%h, required 1/0/0f0f",
                     out_valid, out_sel, out_data);
        end
    endtask

    task automatic test_en_gating();
        do_reset();
        en = 0; req = 4'b0011; out_ready = 1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL en_off_no_grant cyc=%0d: valid=%b, required 0", c, out_valid);
            end
        end
        en = 1; out_ready = 0;
        tick();
        en = 0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_sel !== 2'd0) begin
            failures++;
            $display("FAIL en_busy_hold: valid=%b sel=%0d, required 1/0", out_valid, out_sel);
        end
        out_ready = 1;
        #1;
        checks++;
        if (ack !== 4'b0001) begin
            failures++;
            $display("FAIL en_busy_ack: ack=%b, required 0001", ack);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || ack !== 4'b0000) begin
            failures++;
            $display("FAIL en_to_idle: valid=%b ack=%b, required 0/0000", out_valid, ack);
        end
        en = 1;
    endtask

    task automatic test_mid_reset();
        do_reset();
        req = 4'b1000; in_w[3] = 16'h3C3C; out_ready = 0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_sel !== 2'd3) begin
            failures++;
            $display("FAIL midreset_setup: valid=%b sel=%0d, required 1/3", out_valid, out_sel);
        end
        rst_n = 0; out_ready = 1;
        #1;
        checks++;
        if (ack !== 4'b0000) begin
            failures++;
            $display("FAIL midreset_no_ack: ack=%b, required 0000", ack);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0000) begin
            failures++;
            $display("FAIL midreset_drop: valid=%b data=%h, required 0/0000", out_valid, out_data);
        end
        rst_n = 1; req = 4'b1111; out_ready = 0;
        tick();
        checks++;
        if (out_sel !== 2'd0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL midreset_priority: valid=%b sel=%0d, required 1/0", out_valid, out_sel);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req = 4'($urandom_range(0, 15));
            en = ($urandom_range(0, 7) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 63) != 0);
            for (int i = 0; i < 4; i++) in_w[i] = 16'($urandom);
            #1;
            checks++;
            if (out_valid !== m_valid || out_sel !== m_sel || out_data !== m_data || ack !== exp_ack()) begin
                failures++;
                $display("FAIL random cyc=%0d: valid=%b sel=%0d data=%h ack=%b, required %b/%0d/%h/%b",
                         c, out_valid, out_sel, out_data, ack, m_valid, m_sel, m_data, exp_ack());
            end
            tick();
        end
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0; en = 1; req = 0; out_ready = 0;
        for (int i = 0; i < 4; i++) in_w[i] = 16'h0000;
        m_valid = 0; m_data = 0; m_sel = 0; m_last = 3;
        #2;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_en_gating();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
